conv_layer_seq: RTL

//  Parametrised sequential convolution layer; successor to the single-shot combinational C1 conv wrapper.

---
 rtl/conv_layer_seq_pkg.sv | 49 ++++
 rtl/conv_layer_seq_if.sv | 43 ++++
 rtl/conv_layer_seq_mac_lane.sv | 64 ++++++
 rtl/conv_layer_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/conv_layer_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package   : conv_layer_seq_pkg
// Purpose   : Shared types and helpers for the sequential convolution layer:
//             FSM state encoding, output post-processing (round, saturate)
//             and a width helper for counters.
// Revision  : 1.0 - initial release
// ============================================================================
package conv_layer_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_EMIT = 2'd2
  } conv_state_t;

  // ceil(log2(value)), never less than 1 so that counters for a single
  // position still get a legal 1-bit vector.
  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

  // Round half up at bit FRAC-1, arithmetic shift right by FRAC, then clamp
  // to the signed DW-bit range. Works on a sign-extended 64-bit copy of the
  // accumulator so one function serves every ACC_WIDTH below 64.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                   input int frac,
                                                   input int dw);
    logic signed [63:0] rounded;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] result;
    rounded = acc;
    if (frac > 0) rounded = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (rounded > hi)      result = hi;
    else if (rounded < lo) result = lo;
    else                   result = rounded;
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_layer_seq_if.sv
`default_nettype none
// ============================================================================
// Interface : conv_layer_seq_if
// Purpose   : Output pixel stream of the convolution layer (valid/ready).
// Signals   : out_valid  - pixel on out_data/out_row/out_col is valid
//             out_ready  - consumer accepts on out_valid & out_ready
//             out_data   - OUT_CH lanes, lane oc at [oc*DATA_WIDTH +: DATA_WIDTH]
//             out_row    - output row of the current pixel
//             out_col    - output column of the current pixel
// Modports  : master (producer, the layer), slave (consumer, pooling stage)
// Revision  : 1.0 - initial release
// ============================================================================
interface conv_layer_seq_if #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_CH     = 6,
  parameter int ROW_W      = 5,
  parameter int COL_W      = 5
) ();

  logic                         out_valid;
  logic                         out_ready;
  logic [OUT_CH*DATA_WIDTH-1:0] out_data;
  logic [ROW_W-1:0]             out_row;
  logic [COL_W-1:0]             out_col;

  modport master (
    output out_valid,
    output out_data,
    output out_row,
    output out_col,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_row,
    input  out_col,
    output out_ready
  );

endinterface
`default_nettype wire

// File: rtl/conv_layer_seq_mac_lane.sv
`default_nettype none
// ============================================================================
// Module    : conv_layer_seq_mac_lane
// Purpose   : One output-channel lane: accumulator preset to the scaled bias,
//             one signed multiply-accumulate per cycle, and a registered
//             post-processed (round/saturate/optional ReLU) result.
// Ports     : clk, reset (async, active-low)
//             load     - preset accumulator to bias << FRAC
//             mac      - accumulate sample*weight this cycle
//             last     - this is the final tap: register post(acc + product)
//             relu     - clamp negative results to zero
//             bias, sample, weight - signed DATA_WIDTH operands
//             out_data - registered lane result
// Revision  : 1.0 - initial release
// ============================================================================
module conv_layer_seq_mac_lane
  import conv_layer_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC       = 8,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load,
  input  logic                         mac,
  input  logic                         last,
  input  logic                         relu,
  input  logic signed [DATA_WIDTH-1:0] bias,
  input  logic signed [DATA_WIDTH-1:0] sample,
  input  logic signed [DATA_WIDTH-1:0] weight,
  output logic        [DATA_WIDTH-1:0] out_data
);

  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0]    w_prod_ext;
  logic signed [ACC_WIDTH-1:0]    w_sum;
  logic signed [ACC_WIDTH-1:0]    w_bias_acc;
  logic        [DATA_WIDTH-1:0]   w_sat;
  logic        [DATA_WIDTH-1:0]   w_post;
  logic signed [ACC_WIDTH-1:0]    r_acc;

  assign w_prod     = sample * weight;
  assign w_prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};
  assign w_sum      = r_acc + w_prod_ext;
  // Bias is in the sample Q format; products carry 2*FRAC fraction bits.
  assign w_bias_acc = {{(ACC_WIDTH-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias} << FRAC;
  assign w_sat      = DATA_WIDTH'(sat_round({{(64-ACC_WIDTH){w_sum[ACC_WIDTH-1]}}, w_sum},
                                            FRAC, DATA_WIDTH));
  assign w_post     = (relu && w_sat[DATA_WIDTH-1]) ? '0 : w_sat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc    <= '0;
      out_data <= '0;
    end else begin
      if (load)     r_acc <= w_bias_acc;
      else if (mac) r_acc <= w_sum;
      if (last)     out_data <= w_post;
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_layer_seq.sv
`default_nettype none
// ============================================================================
// Module    : conv_layer_seq
// Purpose   : Sequential convolution layer. Walks the output frame in raster
//             order; for each pixel spends one cycle per kernel tap (all
//             OUT_CH lanes in parallel), then presents the pixel on a
//             valid/ready stream until accepted.
// Ports     : clk, reset (async, active-low)
//             start    - begin a frame (only looked at while idle)
//             relu_en  - ReLU enable, captured with start
//             image    - elem (ic*IMG_H+r)*IMG_W+c, held stable during frame
//             filters  - elem ((oc*IN_CH+ic)*K+kr)*K+kc, held stable
//             bias     - lane oc at [oc*DATA_WIDTH +: DATA_WIDTH], held stable
//             out_if   - output pixel stream (master)
//             busy     - frame in progress
//             done     - one-cycle pulse after the final pixel is accepted
// Revision  : 1.0 - initial release
// ============================================================================
module conv_layer_seq
  import conv_layer_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC       = 8,
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32,
  parameter int IN_CH      = 1,
  parameter int OUT_CH     = 6,
  parameter int KERNEL     = 5,
  parameter int STRIDE     = 1,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic                                    relu_en,
  input  logic [IMG_W*IMG_H*IN_CH*DATA_WIDTH-1:0] image,
  input  logic [KERNEL*KERNEL*IN_CH*OUT_CH*DATA_WIDTH-1:0] filters,
  input  logic [OUT_CH*DATA_WIDTH-1:0]            bias,
  conv_layer_seq_if.master                        out_if,
  output logic                                    busy,
  output logic                                    done
);

  localparam int OUT_W = (IMG_W - KERNEL) / STRIDE + 1;
  localparam int OUT_H = (IMG_H - KERNEL) / STRIDE + 1;
  localparam int TAPS  = KERNEL * KERNEL * IN_CH;
  localparam int ROW_W = clog2_min1(OUT_H);
  localparam int COL_W = clog2_min1(OUT_W);
  localparam int TAP_W = clog2_min1(TAPS);
  localparam int K_W   = clog2_min1(KERNEL);
  localparam int IC_W  = clog2_min1(IN_CH);

  conv_state_t        r_state;
  logic [TAP_W-1:0]   r_tap;
  logic [IC_W-1:0]    r_ic;
  logic [K_W-1:0]     r_kr;
  logic [K_W-1:0]     r_kc;
  logic [ROW_W-1:0]   r_row;
  logic [COL_W-1:0]   r_col;
  logic               r_relu;
  logic               r_valid;

  logic                         w_start;
  logic                         w_fire;
  logic                         w_last_px;
  logic                         w_last_tap;
  logic                         w_load;
  logic                         w_mac;
  int                           w_img_idx;
  logic [DATA_WIDTH-1:0]        w_sample;
  logic [OUT_CH*DATA_WIDTH-1:0] w_lane_data;

  assign w_start    = (r_state == ST_IDLE) && start;
  assign w_fire     = (r_state == ST_EMIT) && out_if.out_ready;
  assign w_last_px  = (r_row == ROW_W'(OUT_H - 1)) && (r_col == COL_W'(OUT_W - 1));
  assign w_mac      = (r_state == ST_MAC);
  assign w_last_tap = w_mac && (r_tap == TAP_W'(TAPS - 1));
  // The accumulator is preset at frame start and after every accepted
  // non-final pixel, so the MAC phase always begins from the bias.
  assign w_load     = w_start || (w_fire && !w_last_px);

  // Sample for tap (ic, kr, kc) of the window anchored at (row, col).
  always_comb begin
    w_img_idx = ((int'(r_ic) * IMG_H + int'(r_row) * STRIDE + int'(r_kr)) * IMG_W)
              + int'(r_col) * STRIDE + int'(r_kc);
  end
  assign w_sample = image[w_img_idx*DATA_WIDTH +: DATA_WIDTH];

  // Filter element order matches the tap order, so lane oc reads its
  // weight at oc*TAPS + tap.
  generate
    for (genvar oc = 0; oc < OUT_CH; oc++) begin : g_lane
      conv_layer_seq_mac_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC       (FRAC),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_lane (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .mac      (w_mac),
        .last     (w_last_tap),
        .relu     (r_relu),
        .bias     (bias[oc*DATA_WIDTH +: DATA_WIDTH]),
        .sample   (w_sample),
        .weight   (filters[(oc*TAPS + int'(r_tap))*DATA_WIDTH +: DATA_WIDTH]),
        .out_data (w_lane_data[oc*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_tap   <= '0;
      r_ic    <= '0;
      r_kr    <= '0;
      r_kc    <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_relu  <= 1'b0;
      r_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_MAC;
            r_tap   <= '0;
            r_ic    <= '0;
            r_kr    <= '0;
            r_kc    <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_relu  <= relu_en;
            busy    <= 1'b1;
          end
        end
        ST_MAC: begin
          if (w_last_tap) begin
            r_state <= ST_EMIT;
            r_valid <= 1'b1;
            r_tap   <= '0;
            r_ic    <= '0;
            r_kr    <= '0;
            r_kc    <= '0;
          end else begin
            r_tap <= r_tap + 1'b1;
            if (r_kc == K_W'(KERNEL - 1)) begin
              r_kc <= '0;
              if (r_kr == K_W'(KERNEL - 1)) begin
                r_kr <= '0;
                r_ic <= r_ic + 1'b1;
              end else begin
                r_kr <= r_kr + 1'b1;
              end
            end else begin
              r_kc <= r_kc + 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (out_if.out_ready) begin
            r_valid <= 1'b0;
            if (w_last_px) begin
              r_state <= ST_IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
              r_row   <= '0;
              r_col   <= '0;
            end else begin
              r_state <= ST_MAC;
              if (r_col == COL_W'(OUT_W - 1)) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
              end else begin
                r_col <= r_col + 1'b1;
              end
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign out_if.out_valid = r_valid;
  assign out_if.out_data  = w_lane_data;
  assign out_if.out_row   = r_row;
  assign out_if.out_col   = r_col;

endmodule
`default_nettype wire
